alu_rr_sequencer: RTL
=====================

Name: alu_rr_sequencer

Overview:
- Shares one 16-bit add/sub/mul/div datapath (registered operands A/B, registered 32-bit result, remainder and flags) between NUM_REQ requesters.
- Round-robin arbitration selects one requester's command. The block then sequences the datapath (operand load, then result capture) and returns the result through a valid/ready response channel tagged with the requester id.
- It sits between the requester ports and the datapath instance, which it drives directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of requester id

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_op  in  2*NUM_REQ  op per requester: 00 add, 01 sub, 10 mul, 11 div
- req_a  in  16*NUM_REQ  operand A per requester
- req_b  in  16*NUM_REQ  operand B per requester
- req_cin  in  NUM_REQ  add carry-in per requester
- req_bin  in  NUM_REQ  sub borrow-in per requester
- alu_d_a  out  16  datapath operand A
- alu_d_b  out  16  datapath operand B
- alu_op_code  out  2  datapath op select
- alu_cin  out  1  datapath carry-in
- alu_bin  out  1  datapath borrow-in
- alu_en_a  out  1  datapath A register enable
- alu_en_b  out  1  datapath B register enable
- alu_en_result  out  1  datapath result register enable
- alu_result  in  32  datapath result
- alu_remainder  in  16  datapath remainder
- alu_flags  in  4  {error, overflow, bout, cout} from datapath
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_result  out  32  result
- rsp_remainder  out  16  remainder
- rsp_flags  out  4  {error, overflow, bout, cout}

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values, all zero: every output, and the rr pointer. State goes to IDLE.
- Reset mid-operation: the in-flight command is dropped and no response is produced.
- Request protocol: requesters hold valid and payload stable until accepted.
- FSM states: IDLE, LOAD, EXEC, RESP.
- IDLE:
  - The winner is the first requester with req_valid=1, searching upward from pointer and wrapping at NUM_REQ-1 -> 0.
  - req_ready[winner]=1 combinationally in IDLE only. With no request, req_ready=0.
  - On handshake: latch op/a/b/cin/bin/id into the command register, set pointer = winner+1 mod NUM_REQ, go LOAD.
- LOAD (1 cycle):
  - Drive alu_d_a, alu_d_b, alu_op_code, alu_cin, alu_bin from the latched command.
  - alu_en_a=alu_en_b=1. Go EXEC.
- EXEC (1 cycle):
  - Hold op/cin/bin. alu_en_result=1, enables A/B=0.
  - Go RESP.
- RESP:
  - rsp_valid=1. rsp_id from latched id. rsp_result/remainder/flags driven from datapath outputs, which are stable because all enables are 0.
  - On rsp_valid&rsp_ready go IDLE. Otherwise hold all values.
- Latency: handshake in cycle 0, rsp_valid in cycle 3. Throughput: one command per 4 cycles when rsp_ready=1.
- Idle outputs: alu_en_* are 0 outside LOAD/EXEC. alu_d_* and alu_op_code hold their last value.
- Simultaneous requests: exactly one grant per IDLE cycle. Pointer fairness guarantees each waiting requester is served within NUM_REQ grants.
- A requester dropping valid without a handshake is a protocol violation and is not checked.

Optional Feature:
- Macro: ALU_DIV0_SHORTCUT_EN.
- Defined: in IDLE, a granted op=11 with b=0 skips LOAD/EXEC and goes straight to RESP with:
  - rsp_result=0, rsp_remainder=0, rsp_flags=4'b1000, driven from internal registers rather than the datapath;
  - the datapath untouched (no enables);
  - latency of 1 cycle.
- Undefined: divide-by-zero follows the normal 3-cycle path. The flags come from the datapath, which reports error=1 and result 0.

Decomposition:
- Package alu_seq_pkg:
  - op code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - state enum;
  - flag bit indices FLAG_COUT=0, FLAG_BOUT=1, FLAG_OVF=2, FLAG_ERR=3.
- One sub-module, rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded id, any_grant.
  - The pointer register stays in the sequencer.

Test Plan:
- Single add: req0 valid, a=16'h0003, b=16'h0004, cin=1, rsp_ready=1. Expect handshake at cycle 0, rsp_valid in cycle 3, rsp_id=0, result=32'h8, flags=0.
- Round-robin: all 4 requesters valid continuously with distinct ops. Expect grant order 0,1,2,3,0, each response tagged with the matching id.
- Backpressure: mul a=16'h0100, b=16'h0100, hold rsp_ready=0 for 5 cycles. Expect rsp_valid held, result=32'h00010000, overflow=1, no new req_ready until rsp handshake.
- Divide: a=100, b=7. Expect result=14, remainder=2, flags=0. Then a=5, b=0: expect error flag=1, result=0. Latency is 1 cycle with ALU_DIV0_SHORTCUT_EN and 3 without, and alu_en_* stays 0 in shortcut mode.
- Reset mid-op: assert rst during EXEC. Next cycle expect all outputs 0, state IDLE, no rsp_valid, pointer 0 (req0 wins next even if req1 also valid).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the round-robin ALU sequencer.
//   - op codes driven on alu_op_code / accepted on req_op
//   - sequencer FSM state encoding
//   - bit positions inside the 4-bit {error, overflow, bout, cout} flag word
//   - latched command payload type
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  localparam int unsigned FLAG_COUT = 0;
  localparam int unsigned FLAG_BOUT = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_ERR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              bin;
  } cmd_t;

  // Flag word reported for a divide-by-zero answered without the datapath.
  function automatic logic [FLAG_W-1:0] div0_flags();
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLAG_ERR] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
// Ports:
//   req       - request vector
//   ptr       - search start index (highest priority this cycle)
//   grant     - one-hot grant, zero when no request
//   grant_id  - encoded index of the granted requester
//   any_grant - at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  // Walk the requesters in priority order; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one add/sub/mul/div datapath between NUM_REQ requesters.
// A round-robin arbiter picks a command in IDLE; the FSM then loads the
// datapath operand registers (LOAD), captures the result (EXEC) and presents
// it on a valid/ready response channel tagged with the requester id (RESP).
// Build option: ALU_DIV0_SHORTCUT_EN - a divide by zero is answered directly
// from IDLE (1-cycle latency) without touching the datapath.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - per-requester command handshake
//   req_op/a/b/cin/bin            - per-requester command payload (packed)
//   alu_d_a/d_b/op_code/cin/bin   - datapath operands and op select
//   alu_en_a/en_b/en_result       - datapath register enables
//   alu_result/remainder/flags    - datapath outputs
//   rsp_valid/rsp_ready           - response handshake
//   rsp_id/result/remainder/flags - response payload
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_bin,
  output logic [DATA_W-1:0]         alu_d_a,
  output logic [DATA_W-1:0]         alu_d_b,
  output logic [OP_W-1:0]           alu_op_code,
  output logic                      alu_cin,
  output logic                      alu_bin,
  output logic                      alu_en_a,
  output logic                      alu_en_b,
  output logic                      alu_en_result,
  input  logic [RES_W-1:0]          alu_result,
  input  logic [DATA_W-1:0]         alu_remainder,
  input  logic [FLAG_W-1:0]         alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_result,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic [FLAG_W-1:0]         rsp_flags
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  cmd_t                cmd_q, cmd_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                en_ab_q, en_ab_d;
  logic                en_res_q, en_res_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                sc_q, sc_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win_id;
  logic                any_grant;
  cmd_t                sel;
  logic                div0_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (win_id),
    .any_grant (any_grant)
  );

  // Payload of the current winner.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel.op  = req_op[OP_W*i +: OP_W];
        sel.a   = req_a[DATA_W*i +: DATA_W];
        sel.b   = req_b[DATA_W*i +: DATA_W];
        sel.cin = req_cin[i];
        sel.bin = req_bin[i];
      end
    end
  end

`ifdef ALU_DIV0_SHORTCUT_EN
  assign div0_c = (sel.op == OP_DIV) && (sel.b == '0);
`else
  assign div0_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    en_ab_d     = 1'b0;
    en_res_d    = 1'b0;
    rsp_valid_d = 1'b0;
    sc_d        = sc_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        // rst gating keeps the combinational grant at zero during reset.
        if (!rst) req_ready = grant;
        if (any_grant) begin
          ptr_d = ID_W'((32'(win_id) + 32'd1) % NUM_REQ);
          id_d  = win_id;
          if (div0_c) begin
            // Datapath operands untouched; answer comes from sc_q.
            sc_d        = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            sc_d    = 1'b0;
            cmd_d   = sel;
            en_ab_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        en_res_d = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cmd_q       <= '0;
      id_q        <= '0;
      en_ab_q     <= 1'b0;
      en_res_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      sc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      id_q        <= id_d;
      en_ab_q     <= en_ab_d;
      en_res_q    <= en_res_d;
      rsp_valid_q <= rsp_valid_d;
      sc_q        <= sc_d;
    end
  end

  assign alu_d_a       = cmd_q.a;
  assign alu_d_b       = cmd_q.b;
  assign alu_op_code   = cmd_q.op;
  assign alu_cin       = cmd_q.cin;
  assign alu_bin       = cmd_q.bin;
  assign alu_en_a      = en_ab_q;
  assign alu_en_b      = en_ab_q;
  assign alu_en_result = en_res_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;

  // Datapath registers are frozen in RESP, so passing them through is stable.
  always_comb begin
    rsp_result    = '0;
    rsp_remainder = '0;
    rsp_flags     = '0;
    if (state_q == RESP) begin
      if (sc_q) begin
        rsp_flags = div0_flags();
      end else begin
        rsp_result           = alu_result;
        rsp_remainder        = alu_remainder;
        rsp_flags[FLAG_COUT] = alu_flags[FLAG_COUT];
        rsp_flags[FLAG_BOUT] = alu_flags[FLAG_BOUT];
        rsp_flags[FLAG_OVF]  = alu_flags[FLAG_OVF];
        rsp_flags[FLAG_ERR]  = alu_flags[FLAG_ERR];
      end
    end
  end

endmodule
